// File: rtl/stim_pattern_gen.sv
// rtl/stim_pattern_gen.sv - multi-channel stimulus sequencer with zero/counter/walking-one/LFSR patterns
// Optional loopback checker (resp, err_cnt, err_flag) is enabled by defining STIM_CHECK_EN.
module stim_pattern_gen #(
    parameter int CH_NUM = 4,
    parameter int DW     = 4,
    parameter int LEN_W  = 16,
    parameter int HOLD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [LEN_W-1:0]         len,
    input  logic [HOLD_W-1:0]        hold,
    input  logic                     pause,
`ifdef STIM_CHECK_EN
    input  logic [CH_NUM*DW-1:0]     resp,
    output logic [15:0]              err_cnt,
    output logic                     err_flag,
`endif
    output logic [CH_NUM*DW-1:0]     stim,
    output logic                     stim_vld,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_W-1:0]         step_cnt
);
    localparam int W = CH_NUM * DW;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    state_t            state;
    logic [1:0]        mode_r;
    logic [LEN_W-1:0]  len_r;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       lfsr;
    logic              adv;
    logic              last_vec;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [W-1:0] vec_of(input logic [1:0] m, input logic [LEN_W-1:0] idx,
                                            input logic [15:0] l);
        logic [W-1:0] v;
        logic [63:0]  rep;
        v   = '0;
        rep = {4{l}};
        case (m)
            2'd1: for (int k = 0; k < CH_NUM; k++) v[k*DW +: DW] = DW'(idx + LEN_W'(k));
            2'd2: v = W'(1) << (32'(idx) % W);
            2'd3: v = rep[W-1:0];
            default: v = '0;
        endcase
        return v;
    endfunction

    // A vector ends after its RUN cycle (hold=0) or after its last HOLD cycle.
    always_comb begin
        adv      = 1'b0;
        last_vec = (step_cnt == len_r - LEN_W'(1));
        if (!pause) begin
            if (state == S_RUN && hold_r == '0)
                adv = 1'b1;
            if (state == S_HOLD && hold_cnt == HOLD_W'(1))
                adv = 1'b1;
        end
    end

    assign stim_vld = (state == S_RUN) && !pause;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_r   <= '0;
            len_r    <= '0;
            hold_r   <= '0;
            hold_cnt <= '0;
            lfsr     <= SEED;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        len_r    <= len;
                        hold_r   <= hold;
                        lfsr     <= SEED;
                        step_cnt <= '0;
                        if (len != '0) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            stim  <= vec_of(mode, '0, SEED);
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!pause && hold_r != '0) begin
                        state    <= S_HOLD;
                        hold_cnt <= hold_r;
                    end
                end
                S_HOLD: begin
                    if (!pause && hold_cnt != HOLD_W'(1))
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                default: state <= S_IDLE;
            endcase

            if (adv) begin
                if (last_vec) begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    stim     <= '0;
                    step_cnt <= '0;
                end else begin
                    state    <= S_RUN;
                    step_cnt <= step_cnt + LEN_W'(1);
                    lfsr     <= lfsr_next(lfsr);
                    stim     <= vec_of(mode_r, step_cnt + LEN_W'(1), lfsr_next(lfsr));
                end
            end
        end
    end

`ifdef STIM_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (stim_vld && resp != stim) begin
            if (err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            err_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stim_pattern_gen.sv
// tb/tb_stim_pattern_gen.sv - scoreboard bench for stim_pattern_gen
module tb_stim_pattern_gen;
    localparam int CH_NUM = 4;
    localparam int DW     = 4;
    localparam int LEN_W  = 16;
    localparam int HOLD_W = 8;
    localparam int W      = CH_NUM * DW;

    logic              clk = 1'b0;
    logic              rst, start, pause;
    logic [1:0]        mode;
    logic [LEN_W-1:0]  len;
    logic [HOLD_W-1:0] hold;
    logic [W-1:0]      stim;
    logic              stim_vld, busy, done;
    logic [LEN_W-1:0]  step_cnt;
`ifdef STIM_CHECK_EN
    logic [W-1:0]      resp;
    logic [15:0]       err_cnt;
    logic              err_flag;
    logic [LEN_W-1:0]  flip_idx = '1;
    assign resp = (stim_vld && step_cnt == flip_idx) ? (stim ^ W'(1)) : stim;
`endif

    stim_pattern_gen #(.CH_NUM(CH_NUM), .DW(DW), .LEN_W(LEN_W), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .hold(hold), .pause(pause),
`ifdef STIM_CHECK_EN
        .resp(resp), .err_cnt(err_cnt), .err_flag(err_flag),
`endif
        .stim(stim), .stim_vld(stim_vld), .busy(busy), .done(done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     v;
        logic [LEN_W-1:0] idx;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    logic [W-1:0] log_v[$];
    int           log_c[$];
    int           cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           checks = 0;
    int           failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference vector computed directly from the pattern rules.
    function automatic logic [W-1:0] model_vec(input int m, input int i);
        logic [W-1:0] v;
        logic [15:0]  l;
        logic [63:0]  r;
        v = '0;
        case (m)
            1: for (int k = 0; k < CH_NUM; k++) v[k*DW +: DW] = DW'((i + k) % (1 << DW));
            2: v = W'(64'(1) << (i % W));
            3: begin
                l = 16'hACE1;
                for (int s = 0; s < i; s++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
                r = {4{l}};
                v = r[W-1:0];
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (stim_vld) begin
                log_v.push_back(stim);
                log_c.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: actual stim=%0h required no strobe", stim);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_stim", stim, e.v);
                    chk("sb_step_cnt", step_cnt, e.idx);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
                chk("stim_at_done", stim, 0);
                chk("step_at_done", step_cnt, 0);
            end
        end
    end

    task automatic do_start(input int m, input int l, input int h, output int s);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 2'(m);
        len   = LEN_W'(l);
        hold  = HOLD_W'(h);
        s     = cyc;
        log_v.delete();
        log_c.delete();
        done_cnt = 0;
        for (int i = 0; i < l; i++) exp_q.push_back('{model_vec(m, i), LEN_W'(i)});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit rp);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                if (rp) pause = ($urandom_range(0, 3) == 0);
            end
        end
        pause = 1'b0;
        if (!got) chk({name, "_timeout"}, 0, 1);
        #1;
    endtask

    task automatic after_run(input string name, input int l);
        chk({name, "_strobes"}, log_v.size(), l);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        chk({name, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, m, l, h, bad;
        rst = 1'b1; start = 1'b0; pause = 1'b0; mode = '0; len = '0; hold = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stim", stim, 0);
        chk("rst_vld", stim_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step_cnt, 0);
`ifdef STIM_CHECK_EN
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_flag", err_flag, 0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        do_start(1, 3, 0, s);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t1_vld", stim_vld, c <= 3);
            chk("t1_busy", busy, c <= 3);
            chk("t1_done", done, c == 4);
        end
        #1;
        chk("t1_v0", log_v[0], 16'h3210);
        chk("t1_v1", log_v[1], 16'h4321);
        chk("t1_v2", log_v[2], 16'h5432);
        chk("t1_first_latency", log_c[0] - s, 1);
        chk("t1_done_cycle", done_cyc - s, 4);
        after_run("t1", 3);

        do_start(2, 18, 2, s);
        wait_done("t2", 200, 0);
        after_run("t2", 18);
        chk("t2_v0", log_v[0], 16'h0001);
        chk("t2_v15", log_v[15], 16'h8000);
        chk("t2_v16", log_v[16], 16'h0001);
        chk("t2_v17", log_v[17], 16'h0002);
        bad = 0;
        for (int i = 1; i < log_c.size(); i++) if (log_c[i] - log_c[i-1] != 3) bad++;
        chk("t2_spacing", bad, 0);
        chk("t2_done_cycle", done_cyc - log_c[17], 3);

        do_start(3, 2, 0, s);
        wait_done("t3a", 50, 0);
        after_run("t3a", 2);
        chk("t3_v0", log_v[0], 16'hACE1);
        chk("t3_v1", log_v[1], 16'hE270);
        do_start(3, 2, 0, s);
        wait_done("t3b", 50, 0);
        chk("t3_reseed", log_v[0], 16'hACE1);

        do_start(0, 0, 0, s);
        @(negedge clk);
        chk("t4_len0_done", done, 1);
        chk("t4_len0_busy", busy, 0);
        chk("t4_len0_vld", stim_vld, 0);
        #1;
        chk("t4_len0_strobes", log_v.size(), 0);

        do_start(1, 5, 1, s);
        repeat (3) @(posedge clk);
        #1; start = 1'b1; mode = 2'd2; len = LEN_W'(2); hold = '0;
        @(posedge clk); #1 start = 1'b0;
        wait_done("t4_busy_start", 100, 0);
        after_run("t4_busy_start", 5);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t4_start_in_done_busy", busy, 0);
        end
        #1;
        chk("t4_start_in_done_strobes", log_v.size(), 5);

        do_start(1, 4, 0, s);
        @(posedge clk); #1 pause = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_pause_stim", stim, 16'h4321);
            chk("t5_pause_vld", stim_vld, 0);
            @(posedge clk); #1;
        end
        pause = 1'b0;
        @(negedge clk);
        chk("t5_release_vld", stim_vld, 1);
        chk("t5_release_stim", stim, 16'h4321);
        wait_done("t5", 50, 0);
        after_run("t5", 4);
        chk("t5_v1_cycle", log_c[1] - s, 7);

        do_start(1, 4, 3, s);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_stim", stim, 0);
        chk("t6_rst_vld", stim_vld, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_step", step_cnt, 0);
        exp_q.delete();
        repeat (6) @(negedge clk);
        #1;
        chk("t6_no_done", done_cnt, 0);

        for (int r = 0; r < 20; r++) begin
            m = $urandom_range(0, 3);
            l = $urandom_range(1, 12);
            h = $urandom_range(0, 3);
            pause = $urandom_range(0, 1);
            do_start(m, l, h, s);
            wait_done("rand", 400, 1);
            after_run("rand", l);
        end

`ifdef STIM_CHECK_EN
        flip_idx = LEN_W'(2);
        do_start(1, 4, 0, s);
        wait_done("chk_run", 50, 0);
        chk("chk_err_cnt", err_cnt, 1);
        chk("chk_err_flag", err_flag, 1);
        flip_idx = '1;
        do_start(1, 2, 0, s);
        @(negedge clk);
        chk("chk_clear_cnt", err_cnt, 0);
        chk("chk_clear_flag", err_flag, 0);
        wait_done("chk_run2", 50, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
